mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator for the data memory: converts CPU-side load/store requests (byte, halfword, word) into word-wide `address`/`data_in`/`write_enable`/`read_enable` memory accesses.
- Performs sub-word extraction and sign extension on loads.
- Performs read-modify-write for sub-word stores, since the memory has no byte enables.
- Sits between the MEM pipeline stage and data_mem; stalls the pipeline through a valid/ready handshake.

Parameters:
- MEM_SIZE, 32, number of 32-bit words in the attached memory.
- READ_LAT, 1, cycles `mem_read_enable` is held before `mem_data_out` is sampled (range 1-15).

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  CPU request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_store  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data; byte/half taken from low bits
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores
- resp_fault  output  1  misaligned (or out-of-range) request; valid with resp_valid
- mem_address  output  32  word index = req_addr[31:2] zero-extended
- mem_data_in  output  32  write data to memory
- mem_write_enable  output  1  memory write strobe
- mem_read_enable  output  1  memory read strobe
- mem_data_out  input  32  memory read data

Behaviour:
- Reset values: state IDLE; `resp_valid`, `resp_fault`, `mem_write_enable`, `mem_read_enable` = 0; `resp_rdata`, `mem_address`, `mem_data_in` = 0. `req_ready` = 1 after reset.
- Reset asserted mid-operation aborts the access at the next edge: any pending sub-word write is dropped and no `resp_valid` is issued.
- All outputs are registered. `mem_write_enable` and `mem_read_enable` are never high in the same cycle, and are 0 in IDLE, RESP and FAULT.
- Handshake: a request is accepted on a cycle with `req_valid` && `req_ready`. Request fields are latched at acceptance; inputs are ignored until the unit returns to IDLE.
- Byte lane: lane = addr[1:0]; little-endian, byte 0 = bits 7:0.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Goes to FAULT with no memory access.
- States and transitions:
  - IDLE: on accept → FAULT if misaligned; else → WRITE if store word; else → READ.
  - READ: `mem_read_enable`=1, `mem_address` = word index. A counter runs READ_LAT cycles; on the last cycle `mem_data_out` is captured. Then → RESP for a load, → WRITE for a sub-word store.
  - WRITE: exactly one cycle with `mem_write_enable`=1.
    - Store word: `mem_data_in` = req_wdata.
    - Sub-word store: `mem_data_in` = captured word with the addressed byte/half lane replaced by req_wdata[7:0]/[15:0].
    - Then → RESP.
  - RESP: `resp_valid`=1 for one cycle, `resp_fault`=0, then → IDLE.
  - FAULT: `resp_valid`=1 and `resp_fault`=1 for one cycle, `resp_rdata`=0, then → IDLE.
- Load result:
  - Byte load selects the lane byte; half load selects bits [15:0] if addr[1]=0, else [31:16].
  - Extension per req_signed; word loads ignore req_signed.
- Latency from accept to `resp_valid`:
  - load: READ_LAT+1 cycles
  - store word: 2 cycles
  - sub-word store: READ_LAT+2 cycles
  - fault: 1 cycle
- Back-to-back: `req_ready` rises in the cycle after RESP/FAULT; the minimum issue interval is therefore latency+1.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined: an aligned request whose word index is >= MEM_SIZE goes to FAULT (`resp_fault`=1) with no memory strobe. Misalignment still takes priority, but both paths produce the same response.
- Undefined: no range check; the word index is driven unmodified and the memory's own behaviour applies.

Test Plan:
- Store word: addr 0x10, wdata 0xDEADBEEF → one WRITE cycle with `mem_address`=4, `mem_data_in`=0xDEADBEEF; `resp_valid` 2 cycles after accept, `resp_fault`=0.
- Signed byte loads from word 4 = 0xDEADBEEF (READ_LAT=1): byte load addr 0x13 signed → `resp_rdata`=0xFFFFFFDE. Byte load addr 0x12 unsigned → 0x000000AD.
- Half load: addr 0x12 signed → 0xFFFFDEAD. Addr 0x10 unsigned → 0x0000BEEF.
- Sub-word store: byte store 0x55 to addr 0x11 over 0xDEADBEEF → READ then WRITE with `mem_data_in`=0xDEAD55EF; a subsequent word load of addr 0x10 returns 0xDEAD55EF.
- Misaligned: word load at 0x12 → `resp_valid` & `resp_fault` 1 cycle after accept; both memory enables stay 0 throughout.
- Reset during READ of a byte store → no WRITE strobe, no `resp_valid`; `req_ready`=1 the cycle after reset deasserts; memory word is unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store to word-memory initiator with sub-word RMW; optional MEM_BOUNDS_CHECK_EN range fault
module mem_access_unit #(
   parameter int MEM_SIZE = 32,
   parameter int READ_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_write_enable,
   output logic        mem_read_enable,
   input  logic [31:0] mem_data_out
);
   typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, FAULT} state_t;
   state_t      state;
   logic [3:0]  cnt;
   logic        st, sg;
   logic [1:0]  sz, ln;
   logic [31:0] wd;
   logic        misaligned, oob, bad;

   if (READ_LAT < 1 || READ_LAT > 15 || MEM_SIZE < 1) begin : g_bad_param
      $error("mem_access_unit: READ_LAT must be 1..15 and MEM_SIZE >= 1");
   end

   function automatic logic [4:0] shamt(input logic half, input logic [1:0] l);
      return half ? {l[1], 4'b0} : {l, 3'b0};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                         input logic half, input logic [1:0] l);
      logic [31:0] m;
      m = (half ? 32'h0000_FFFF : 32'h0000_00FF) << shamt(half, l);
      return (w & ~m) | ((d << shamt(half, l)) & m);
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] s,
                                           input logic [1:0] l, input logic g);
      logic [15:0] v;
      v = 16'(w >> shamt(s[0], l));
      return s[1] ? w : s[0] ? {{16{g & v[15]}}, v} : {{24{g & v[7]}}, v[7:0]};
   endfunction

   assign misaligned = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && |req_addr[1:0]);
`ifdef MEM_BOUNDS_CHECK_EN
   assign oob = {2'b00, req_addr[31:2]} >= 32'(MEM_SIZE);
`else
   assign oob = 1'b0;
`endif
   assign bad = misaligned | oob;

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         req_ready        <= 1'b1;
         resp_valid       <= 1'b0;
         resp_fault       <= 1'b0;
         resp_rdata       <= '0;
         mem_address      <= '0;
         mem_data_in      <= '0;
         mem_write_enable <= 1'b0;
         mem_read_enable  <= 1'b0;
         cnt              <= '0;
         st               <= 1'b0;
         sg               <= 1'b0;
         sz               <= '0;
         ln               <= '0;
         wd               <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               st          <= req_store;
               sz          <= req_size;
               sg          <= req_signed;
               ln          <= req_addr[1:0];
               wd          <= req_wdata;
               mem_address <= {2'b00, req_addr[31:2]};
               cnt         <= '0;
               req_ready   <= 1'b0;
               if (bad) begin
                  state      <= FAULT;
                  resp_valid <= 1'b1;
                  resp_fault <= 1'b1;
                  resp_rdata <= '0;
               end else if (req_store && req_size[1]) begin
                  state            <= WRITE;
                  mem_write_enable <= 1'b1;
                  mem_data_in      <= req_wdata;
               end else begin
                  state           <= READ;
                  mem_read_enable <= 1'b1;
               end
            end
            READ: if (cnt == 4'(READ_LAT - 1)) begin
               mem_read_enable <= 1'b0;
               if (st) begin
                  state            <= WRITE;
                  mem_write_enable <= 1'b1;
                  mem_data_in      <= merge(mem_data_out, wd, sz[0], ln);
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= extract(mem_data_out, sz, ln, sg);
               end
            end else begin
               cnt <= cnt + 4'd1;
            end
            WRITE: begin
               state            <= RESP;
               mem_write_enable <= 1'b0;
               resp_valid       <= 1'b1;
               resp_rdata       <= '0;
            end
            RESP, FAULT: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_fault <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
